// File: rtl/sw_bounce_gen.sv
// sw_bounce_gen: drives a bouncing switch contact that follows a clean level.
// Define BOUNCE_RAND_EN for LFSR-randomised bounce intervals (else fixed 2 ticks).
`timescale 1ns/1ps
module sw_bounce_gen #(
   parameter int          TICK_DIV     = 1000000,
   parameter int          NBOUNCE      = 6,
   parameter int          SETTLE_TICKS = 4,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter logic        INIT_LVL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic lvl,
   output logic sw,
   output logic busy,
   output logic done
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

   if (SEED == 16'h0 || NBOUNCE < 0 || NBOUNCE > 15 || (NBOUNCE % 2) != 0 ||
       SETTLE_TICKS < 1 || SETTLE_TICKS > 15) begin : g_bad_param
      $error("sw_bounce_gen: illegal parameter value");
   end

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [3:0]      ivl_q, ivl_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      set_q, set_d;
   logic            sw_q, sw_d;
   logic            tgt_q, tgt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tick;
   logic            expire;
   logic            load;
   logic [3:0]      ld_val;

`ifdef BOUNCE_RAND_EN
   logic [15:0]     lfsr_q, lfsr_d;

   assign ld_val = {1'b0, lfsr_q[2:0]} + 4'd1;
   assign lfsr_d = load ? {lfsr_q[14:0],
                           lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                        : lfsr_q;
`else
   assign ld_val = 4'd2;
`endif

   assign tick   = (pre_q == PW'(TICK_DIV - 1));
   assign expire = tick && (ivl_q == 4'd1);

   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + PW'(1);
      ivl_d   = (tick && ivl_q != 4'd0) ? ivl_q - 4'd1 : ivl_q;
      cnt_d   = cnt_q;
      set_d   = set_q;
      sw_d    = sw_q;
      tgt_d   = tgt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (lvl != sw_q) begin
               tgt_d  = lvl;
               cnt_d  = 4'd0;
               set_d  = 4'd0;
               load   = 1'b1;
               busy_d = 1'b1;
               if (NBOUNCE == 0) begin
                  state_d = SETTLE;
                  sw_d    = lvl;
               end else begin
                  state_d = BOUNCE;
               end
            end
         end
         BOUNCE: begin
            if (expire) begin
               cnt_d = cnt_q + 4'd1;
               load  = 1'b1;
               // final expiry lands on the target instead of toggling
               if (cnt_q == 4'(NBOUNCE - 1)) begin
                  state_d = SETTLE;
                  sw_d    = tgt_q;
                  set_d   = 4'd0;
               end else begin
                  sw_d = ~sw_q;
               end
            end
         end
         SETTLE: begin
            if (tick) begin
               if (set_q == 4'(SETTLE_TICKS - 1)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  set_d = set_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (load) ivl_d = ld_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         ivl_q   <= 4'd0;
         cnt_q   <= 4'd0;
         set_q   <= 4'd0;
         sw_q    <= INIT_LVL;
         tgt_q   <= INIT_LVL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef BOUNCE_RAND_EN
         lfsr_q  <= SEED;
`endif
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         ivl_q   <= ivl_d;
         cnt_q   <= cnt_d;
         set_q   <= set_d;
         sw_q    <= sw_d;
         tgt_q   <= tgt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef BOUNCE_RAND_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   assign sw   = sw_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// tb_sw_bounce_gen: scoreboard bench for sw_bounce_gen, edge-accurate sw/done checks.
// u0 uses default NBOUNCE, u1 uses NBOUNCE=0.
`timescale 1ns/1ps
module tb_sw_bounce_gen;

   localparam int TD = 4;
   localparam int NB = 6;
   localparam int ST = 4;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic lvl0 = 1'b0;
   logic lvl1 = 1'b0;
   logic sw0, busy0, done0;
   logic sw1, busy1, done1;

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int tog0     = 0;
   int nd0      = 0;
   int nd1      = 0;
   logic p0     = 1'b0;
   logic p1     = 1'b0;

   int   ev0_e[$];
   logic ev0_v[$];
   int   dn0[$];
   int   ev1_e[$];
   logic ev1_v[$];
   int   dn1[$];

`ifdef BOUNCE_RAND_EN
   logic [15:0] lf = 16'hACE1;
`endif

   always #5 clk = ~clk;

   sw_bounce_gen #(
      .TICK_DIV(TD), .NBOUNCE(NB), .SETTLE_TICKS(ST),
      .SEED(16'hACE1), .INIT_LVL(1'b0)
   ) u0 (
      .clk(clk), .rst(rst), .lvl(lvl0),
      .sw(sw0), .busy(busy0), .done(done0)
   );

   sw_bounce_gen #(
      .TICK_DIV(TD), .NBOUNCE(0), .SETTLE_TICKS(ST),
      .SEED(16'hACE1), .INIT_LVL(1'b0)
   ) u1 (
      .clk(clk), .rst(rst), .lvl(lvl1),
      .sw(sw1), .busy(busy1), .done(done1)
   );

   always @(posedge clk or posedge rst)
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // first tick edge strictly after edge t (prescaler ticks on edges TD, 2TD, ...)
   function automatic int nxt(input int t);
      return (t / TD + 1) * TD;
   endfunction

   task automatic get_ivl(output int iv);
`ifdef BOUNCE_RAND_EN
      iv = int'(lf[2:0]) + 1;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`else
      iv = 2;
`endif
   endtask

   task automatic plan0(input int e, input logic from, input logic to,
                        output int d);
      int   cur;
      int   iv;
      int   c;
      logic v;
      cur = e;
      v   = from;
      c   = 0;
      get_ivl(iv);
      while (c < NB) begin
         for (int i = 0; i < iv; i++) cur = nxt(cur);
         c++;
         get_ivl(iv);
         if (c == NB) begin
            if (v != to) begin
               ev0_e.push_back(cur);
               ev0_v.push_back(to);
            end
         end else begin
            v = ~v;
            ev0_e.push_back(cur);
            ev0_v.push_back(v);
         end
      end
      for (int i = 0; i < ST; i++) cur = nxt(cur);
      dn0.push_back(cur);
      d = cur;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         p0 <= sw0;
         p1 <= sw1;
      end else begin
         if (sw0 !== p0) begin
            tog0 <= tog0 + 1;
            if (ev0_e.size() == 0) chk("u0_sw_unexpected", edge_n, -1);
            else begin
               chk("u0_sw_edge", edge_n, ev0_e.pop_front());
               chk("u0_sw_val", sw0, ev0_v.pop_front());
            end
         end
         if (done0) begin
            nd0 <= nd0 + 1;
            chk("u0_busy_with_done", busy0, 0);
            if (dn0.size() == 0) chk("u0_done_unexpected", edge_n, -1);
            else chk("u0_done_edge", edge_n, dn0.pop_front());
         end
         if (sw1 !== p1) begin
            if (ev1_e.size() == 0) chk("u1_sw_unexpected", edge_n, -1);
            else begin
               chk("u1_sw_edge", edge_n, ev1_e.pop_front());
               chk("u1_sw_val", sw1, ev1_v.pop_front());
            end
         end
         if (done1) begin
            nd1 <= nd1 + 1;
            chk("u1_busy_with_done", busy1, 0);
            if (dn1.size() == 0) chk("u1_done_unexpected", edge_n, -1);
            else chk("u1_done_edge", edge_n, dn1.pop_front());
         end
         p0 <= sw0;
         p1 <= sw1;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((ev0_e.size() + dn0.size() + ev1_e.size() + dn1.size()) != 0
             && k < maxc) begin
         step();
         k++;
      end
      chk("drain_pending",
          ev0_e.size() + dn0.size() + ev1_e.size() + dn1.size(), 0);
      repeat (3) step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int d;
      int base;
      int k;

      // reset state
      #12;
      chk("rst_sw0", sw0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_sw1", sw1, 0);
      @(negedge clk);
      #1 rst = 1'b0;

      // level matches: nothing happens for 200 cycles
      repeat (200) step();
      chk("idle_sw0", sw0, 0);
      chk("idle_busy0", busy0, 0);
      chk("idle_toggles", tog0, 0);
      chk("idle_done_count", nd0, 0);

      // 0->1 with a lvl glitch mid-bounce that must be ignored
      e = edge_n + 1;
      plan0(e, 1'b0, 1'b1, d);
      lvl0 = 1'b1;
      repeat (10) step();
      chk("bounce_busy0", busy0, 1);
      lvl0 = 1'b0;
      repeat (3) step();
      lvl0 = 1'b1;
      drain(600);
      chk("rise_sw0", sw0, 1);
      chk("rise_busy0", busy0, 0);
      chk("rise_toggles", tog0, NB - 1);
      chk("rise_done_count", nd0, 1);

      // 1->0, then a pending 0->1 set during SETTLE
      e = edge_n + 1;
      plan0(e, 1'b1, 1'b0, d);
      lvl0 = 1'b0;
      k = 0;
      while (edge_n < d - 4 && k < 600) begin
         step();
         k++;
      end
      chk("settle_reached", edge_n >= d - 4, 1);
      chk("settle_busy0", busy0, 1);
      plan0(d + 1, 1'b0, 1'b1, d);
      lvl0 = 1'b1;
      base = tog0;

      // abort with reset after the third toggle of the pending transition
      k = 0;
      while (tog0 < base + 3 && k < 600) begin
         step();
         k++;
      end
      chk("third_toggle_seen", tog0 - base, 3);
      rst = 1'b1;
      #1;
      chk("abort_sw0", sw0, 0);
      chk("abort_busy0", busy0, 0);
      chk("abort_done0", done0, 0);
      ev0_e.delete();
      ev0_v.delete();
      dn0.delete();
`ifdef BOUNCE_RAND_EN
      lf = 16'hACE1;
`endif
      repeat (3) step();
      chk("abort_done_count", nd0, 2);

      // resume from IDLE: lvl0 is still 1, so a transition starts at once
      plan0(1, 1'b0, 1'b1, d);
      rst = 1'b0;
      drain(600);
      chk("resume_sw0", sw0, 1);
      chk("resume_busy0", busy0, 0);
      chk("resume_done_count", nd0, 3);

      // NBOUNCE=0: sw follows one edge later, done after SETTLE_TICKS ticks
      e = edge_n + 1;
      ev1_e.push_back(e);
      ev1_v.push_back(1'b1);
      d = e;
      for (int i = 0; i < ST; i++) d = nxt(d);
      dn1.push_back(d);
      lvl1 = 1'b1;
      step();
      chk("nb0_sw1", sw1, 1);
      chk("nb0_busy1", busy1, 1);
      drain(200);
      chk("nb0_busy1_after", busy1, 0);
      chk("nb0_done_count", nd1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
